// File: rtl/rng_sop_collector.sv
`default_nettype none
// ============================================================================
// Module      : rng_sop_collector
// Description : Samples a raw noise bit every P clocks, optionally applies
//               von Neumann debiasing, and packs the resulting bits
//               MSB-first into SOP_W-bit words behind a one-entry buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module rng_sop_collector #(
  parameter int SOP_W  = 128,
  parameter int SCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rng_en,
  input  logic              vn_en,
  input  logic [SCNT_W-1:0] sample_cnt,
  input  logic              divided_rnd_src,
  input  logic              rd_sop,
  output logic [SOP_W-1:0]  sop_data,
  output logic              sop_valid,
  output logic              rng_busy
);

  localparam int                BCNT_W = $clog2(SOP_W + 1);
  localparam logic [BCNT_W-1:0] C_FULL = BCNT_W'(SOP_W);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WAIT    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SCNT_W-1:0] r_period;
  logic [SCNT_W-1:0] r_pcnt;
  logic [BCNT_W-1:0] r_bcnt;
  logic [SOP_W-1:0]  r_shreg;
  logic              r_vn_mode;
  logic              r_vn_have;
  logic              r_vn_first;

  logic              w_full;
  logic              w_buf_free;
  logic              w_start;
  logic              w_abort;
  logic              w_xfer;
  logic              w_sample_en;
  logic              w_strobe;
  logic              w_bit_valid;
  logic              w_bit;
  logic [SCNT_W-1:0] w_period_last;

  assign rng_busy = (r_state != S_IDLE);

  // Control decode: transfer, sampling strobe and debiased output bit
  always_comb begin
    w_full        = (r_bcnt == C_FULL);
    w_buf_free    = !sop_valid || rd_sop;
    w_start       = (r_state == S_IDLE) && rng_en;
    w_abort       = (r_state != S_IDLE) && !rng_en;
    w_xfer        = (r_state != S_IDLE) && rng_en && w_full && w_buf_free;
    // A full shreg facing an occupied buffer stalls sampling so no bit is lost
    w_sample_en   = (r_state == S_COLLECT) && rng_en && (!w_full || w_buf_free);
    w_period_last = r_period - SCNT_W'(1);
    w_strobe      = w_sample_en && (r_pcnt == w_period_last);
    w_bit_valid   = 1'b0;
    w_bit         = divided_rnd_src;
    if (w_strobe) begin
      if (!r_vn_mode) begin
        w_bit_valid = 1'b1;
      end else if (r_vn_have) begin
        // Pair 10 -> 1, 01 -> 0: the emitted bit equals the first sample
        w_bit_valid = (r_vn_first != divided_rnd_src);
        w_bit       = r_vn_first;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (rng_en) w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        if (!rng_en)                     w_state_nxt = S_IDLE;
        else if (w_full && !w_buf_free)  w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!rng_en)     w_state_nxt = S_IDLE;
        else if (rd_sop) w_state_nxt = S_COLLECT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Sampling datapath: period counter, VN half-pair, shift register, bit count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period   <= SCNT_W'(1);
      r_pcnt     <= '0;
      r_bcnt     <= '0;
      r_shreg    <= '0;
      r_vn_mode  <= 1'b0;
      r_vn_have  <= 1'b0;
      r_vn_first <= 1'b0;
    end else if (w_start) begin
      r_period   <= (sample_cnt == '0) ? SCNT_W'(1) : sample_cnt;
      r_vn_mode  <= vn_en;
      r_pcnt     <= '0;
      r_bcnt     <= '0;
      r_shreg    <= '0;
      r_vn_have  <= 1'b0;
      r_vn_first <= 1'b0;
    end else if (w_abort) begin
      r_pcnt     <= '0;
      r_bcnt     <= '0;
      r_shreg    <= '0;
      r_vn_have  <= 1'b0;
      r_vn_first <= 1'b0;
    end else begin
      if (w_sample_en) r_pcnt <= w_strobe ? '0 : r_pcnt + SCNT_W'(1);
      if (w_strobe && r_vn_mode) begin
        r_vn_have <= !r_vn_have;
        if (!r_vn_have) r_vn_first <= divided_rnd_src;
      end
      // On a transfer the count restarts, absorbing any bit taken that cycle
      if (w_xfer)           r_bcnt <= w_bit_valid ? BCNT_W'(1) : '0;
      else if (w_bit_valid) r_bcnt <= r_bcnt + BCNT_W'(1);
      if (w_bit_valid) r_shreg <= {r_shreg[SOP_W-2:0], w_bit};
    end
  end

  // One-entry output buffer; only reset clears the data word
  always_ff @(posedge clk) begin
    if (rst) begin
      sop_data  <= '0;
      sop_valid <= 1'b0;
    end else if (w_xfer) begin
      sop_data  <= r_shreg;
      sop_valid <= 1'b1;
    end else if (rd_sop && sop_valid) begin
      sop_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rng_sop_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_rng_sop_collector
// Description : Randomized self-checking bench for rng_sop_collector against
//               a bit-queue reference model of the collector behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rng_sop_collector;

  localparam int SOP_W  = 128;
  localparam int SCNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              rng_en;
  logic              vn_en;
  logic [SCNT_W-1:0] sample_cnt;
  logic              divided_rnd_src;
  logic              rd_sop;
  logic [SOP_W-1:0]  sop_data;
  logic              sop_valid;
  logic              rng_busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: accepted bits held in a queue, word formed when full
  bit               m_run;
  bit               m_stall;
  bit               m_vn;
  bit               m_valid;
  int               m_p;
  int               m_phase;
  int               m_half;
  bit               m_bits[$];
  logic [SOP_W-1:0] m_out;

  always #5 clk = ~clk;

  rng_sop_collector #(.SOP_W(SOP_W), .SCNT_W(SCNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .rng_en          (rng_en),
    .vn_en           (vn_en),
    .sample_cnt      (sample_cnt),
    .divided_rnd_src (divided_rnd_src),
    .rd_sop          (rd_sop),
    .sop_data        (sop_data),
    .sop_valid       (sop_valid),
    .rng_busy        (rng_busy)
  );

  task automatic check_val(input string tag, input logic [SOP_W-1:0] got,
                           input logic [SOP_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [SOP_W-1:0] pack_bits();
    logic [SOP_W-1:0] w = '0;
    for (int i = 0; i < SOP_W; i++) w[SOP_W-1-i] = m_bits[i];
    return w;
  endfunction

  // Advance the model by one clock using the inputs currently driven
  function automatic void model_step();
    bit               full;
    bit               free_buf;
    bit               xfer = 1'b0;
    bit               take;
    bit               pop;
    logic [SOP_W-1:0] word = '0;
    pop = rd_sop && m_valid;
    if (rst) begin
      m_run = 0; m_stall = 0; m_valid = 0; m_out = '0;
      m_bits.delete(); m_half = -1; m_phase = 0;
      return;
    end
    if (!m_run) begin
      if (rng_en) begin
        m_run = 1; m_stall = 0; m_vn = vn_en;
        m_p = (sample_cnt == 0) ? 1 : int'(sample_cnt);
        m_phase = 0; m_half = -1; m_bits.delete();
      end
    end else if (!rng_en) begin
      m_run = 0; m_stall = 0; m_half = -1; m_bits.delete();
    end else begin
      full     = (m_bits.size() == SOP_W);
      free_buf = !m_valid || rd_sop;
      xfer     = full && free_buf;
      take     = !m_stall && (!full || free_buf);
      if (xfer) begin
        word = pack_bits();
        m_bits.delete();
      end
      if (take) begin
        m_phase++;
        if (m_phase == m_p) begin
          m_phase = 0;
          if (!m_vn) m_bits.push_back(divided_rnd_src);
          else if (m_half < 0) m_half = int'(divided_rnd_src);
          else begin
            if (m_half != int'(divided_rnd_src)) m_bits.push_back(m_half[0]);
            m_half = -1;
          end
        end
      end
      m_stall = full && !free_buf;
    end
    if (xfer) begin
      m_out = word; m_valid = 1;
    end else if (pop) begin
      m_valid = 0;
    end
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_val("busy",  {127'b0, rng_busy},  {127'b0, m_run});
    check_val("valid", {127'b0, sop_valid}, {127'b0, m_valid});
    check_val("data",  sop_data, m_out);
  endtask

  task automatic drain();
    if (m_valid) begin
      rd_sop = 1'b1; cycle(); rd_sop = 1'b0;
    end
  endtask

  task automatic stop_run();
    rng_en = 1'b0; cycle(); drain(); cycle();
  endtask

  initial begin
    logic [SOP_W-1:0] ones   = '1;
    logic [SOP_W-1:0] onehot = '0;
    int               guard;
    onehot[SOP_W-1] = 1'b1;
    m_out = '0; m_half = -1;
    rst = 1'b1; rng_en = 1'b0; vn_en = 1'b0; sample_cnt = 16'd1;
    divided_rnd_src = 1'b0; rd_sop = 1'b0;
    repeat (3) cycle();
    check_val("reset_data",  sop_data, '0);
    check_val("reset_valid", {127'b0, sop_valid}, '0);
    check_val("reset_busy",  {127'b0, rng_busy}, '0);
    rst = 1'b0;
    cycle();

    // Baseline P=1, constant 1, no reads: first word, then stall in WAIT
    rng_en = 1'b1; divided_rnd_src = 1'b1;
    repeat (131) cycle();
    check_val("base_word", sop_data, ones);
    repeat (170) cycle();
    rd_sop = 1'b1; cycle(); rd_sop = 1'b0;
    check_val("bp_valid_kept", {127'b0, sop_valid}, 128'd1);
    repeat (20) cycle();

    // Abort after ~50 bits, then re-enable for a full fresh word
    drain();
    stop_run();
    rng_en = 1'b1; cycle();
    repeat (50) begin divided_rnd_src = 1'($urandom); cycle(); end
    rng_en = 1'b0; cycle();
    check_val("abort_busy", {127'b0, rng_busy}, '0);
    rng_en = 1'b1;
    repeat (140) begin divided_rnd_src = 1'($urandom); cycle(); end
    stop_run();

    // Bit order: single leading 1, sample_cnt=0 treated as period 1
    sample_cnt = '0; rng_en = 1'b1; divided_rnd_src = 1'b0; cycle();
    divided_rnd_src = 1'b1; cycle();
    divided_rnd_src = 1'b0;
    repeat (132) cycle();
    check_val("bit_order", sop_data, onehot);
    stop_run();

    // Von Neumann, P=2, source toggles 1,0 per sample
    sample_cnt = 16'd2; vn_en = 1'b1; rng_en = 1'b1; cycle();
    for (int k = 0; k < 520; k++) begin
      divided_rnd_src = ((k >> 1) & 1) == 0;
      cycle();
    end
    check_val("vn_valid", {127'b0, sop_valid}, 128'd1);
    check_val("vn_word",  sop_data, ones);
    stop_run();

    // Von Neumann with constant source never produces a word
    rng_en = 1'b1; divided_rnd_src = 1'b1;
    repeat (300) cycle();
    check_val("vn_const_valid", {127'b0, sop_valid}, '0);
    stop_run();

    // Read exactly when the shift register fills
    vn_en = 1'b0; sample_cnt = 16'd1; rng_en = 1'b1;
    for (int k = 0; k < 420; k++) begin
      divided_rnd_src = 1'($urandom);
      rd_sop = m_run && (m_bits.size() == SOP_W);
      cycle();
    end
    rd_sop = 1'b0;
    stop_run();

    // Randomized segments
    for (int s = 0; s < 6; s++) begin
      sample_cnt = SCNT_W'($urandom_range(0, 3));
      vn_en      = 1'($urandom);
      for (int k = 0; k < 500; k++) begin
        rng_en          = ($urandom_range(0, 199) != 0);
        divided_rnd_src = 1'($urandom);
        rd_sop          = ($urandom_range(0, 7) == 0);
        cycle();
      end
      rd_sop = 1'b0;
      stop_run();
    end

    // Reset while stalled in WAIT
    vn_en = 1'b0; sample_cnt = 16'd1; rng_en = 1'b1; divided_rnd_src = 1'b1;
    guard = 0;
    while (!m_stall && guard < 400) begin cycle(); guard++; end
    cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    check_val("rst_wait_valid", {127'b0, sop_valid}, '0);
    check_val("rst_wait_data",  sop_data, '0);
    check_val("rst_wait_busy",  {127'b0, rng_busy}, '0);
    rng_en = 1'b0; cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
